// File: rtl/uart_proto_pkg.sv
// uart_proto_pkg: ASCII command protocol shared by wb2uart and uart2wb.
// Holds the command characters, FSM state type and hex helpers.
package uart_proto_pkg;

    localparam logic [7:0] CH_SYNC = 8'h2E;
    localparam logic [7:0] CH_ADDR = 8'h70;
    localparam logic [7:0] CH_WR   = 8'h77;
    localparam logic [7:0] CH_RD   = 8'h72;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_SYNC,
        ST_ADDR_CMD,
        ST_ADDR_NIB,
        ST_OP_CMD,
        ST_DATA_NIB,
        ST_RX_HI,
        ST_RX_LO,
        ST_DONE,
        ST_ABORT
    } wb2uart_state_e;

    typedef struct packed {
        logic       valid;
        logic [3:0] nib;
    } hex_dec_t;

    // Nibble to uppercase ASCII hex digit.
    function automatic logic [7:0] nib_to_hex(input logic [3:0] n);
        if (n < 4'd10) return 8'h30 + {4'h0, n};
        return 8'h37 + {4'h0, n};
    endfunction

    // Uppercase ASCII hex digit to nibble; anything else is invalid.
    function automatic hex_dec_t hex_to_nib(input logic [7:0] c);
        hex_dec_t r;
        r.valid = 1'b0;
        r.nib   = 4'h0;
        if (c >= 8'h30 && c <= 8'h39) begin
            r.valid = 1'b1;
            r.nib   = c[3:0];
        end else if (c >= 8'h41 && c <= 8'h46) begin
            r.valid = 1'b1;
            r.nib   = c[3:0] + 4'd9;
        end
        return r;
    endfunction

endpackage

// File: rtl/uart_char_sender.sv
// uart_char_sender: hands one character at a time to the UART transmitter,
// waiting out tx_busy and never strobing on two consecutive cycles.
module uart_char_sender (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req,
    input  logic [7:0] ch,
    input  logic       tx_busy,
    output logic       send,
    output logic [7:0] tx_dat,
    output logic       done
);

    logic       send_q, send_d;
    logic [7:0] tx_dat_q, tx_dat_d;

    // Fire when asked, the UART is free and we did not fire last cycle
    // (tx_busy only rises the cycle after a strobe).
    always_comb begin
        send_d   = req && !tx_busy && !send_q;
        tx_dat_d = send_d ? ch : tx_dat_q;
    end

    // Registered strobe and held character.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            send_q   <= 1'b0;
            tx_dat_q <= 8'h00;
        end else begin
            send_q   <= send_d;
            tx_dat_q <= tx_dat_d;
        end
    end

    assign done   = send_d;
    assign send   = send_q;
    assign tx_dat = tx_dat_q;

endmodule

// File: rtl/wb2uart.sv
// wb2uart: Wishbone slave that tunnels byte reads/writes over the UART
// command protocol, caching the remote address and resyncing on errors.
module wb2uart
    import uart_proto_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic        i_wb_clk,
    input  logic        i_wb_rst_n,
    input  logic        i_wb_cyc,
    input  logic        i_wb_stb,
    input  logic        i_wb_we,
    input  logic [23:0] i_wb_addr,
    input  logic [7:0]  i_wb_dat,
    output logic [7:0]  o_wb_dat,
    output logic        o_wb_ack,
    output logic        o_wb_err,
    output logic [7:0]  tx_dat,
    output logic        send,
    input  logic        tx_busy,
    input  logic [7:0]  rx_dat,
    input  logic        received
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    wb2uart_state_e state_q, state_d;
    logic [23:0]    addr_q, addr_d;
    logic           we_q, we_d;
    logic [7:0]     wdat_q, wdat_d;
    logic [23:0]    cache_q, cache_d;
    logic           avld_q, avld_d;
    logic           resync_q, resync_d;
    logic [2:0]     nib_q, nib_d;
    logic [3:0]     rhi_q, rhi_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           drop_q, drop_d;
    logic           fail_q, fail_d;
    logic [7:0]     rdat_q, rdat_d;
    logic           ack_q, ack_d;
    logic           err_q, err_d;

    logic       req;
    logic [7:0] ch;
    logic       done;
    logic       addr_hit;
    logic       live;
    logic [3:0] addr_nib;
    hex_dec_t   rx_dec;

    assign addr_hit = avld_q && (addr_q == cache_q);
    assign live     = !drop_q && i_wb_cyc;
    assign rx_dec   = hex_to_nib(rx_dat);

    // Address nibbles go out low byte first, high nibble first per byte.
    always_comb begin
        addr_nib = addr_q[19:16];
        unique case (nib_q)
            3'd0:    addr_nib = addr_q[7:4];
            3'd1:    addr_nib = addr_q[3:0];
            3'd2:    addr_nib = addr_q[15:12];
            3'd3:    addr_nib = addr_q[11:8];
            3'd4:    addr_nib = addr_q[23:20];
            default: addr_nib = addr_q[19:16];
        endcase
    end

    // Command sequencing, reply decoding, timeout and recovery.
    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        we_d     = we_q;
        wdat_d   = wdat_q;
        cache_d  = cache_q;
        avld_d   = avld_q;
        resync_d = resync_q;
        nib_d    = nib_q;
        rhi_d    = rhi_q;
        cnt_d    = cnt_q;
        drop_d   = drop_q;
        fail_d   = fail_q;
        rdat_d   = rdat_q;
        ack_d    = 1'b0;
        err_d    = 1'b0;
        req      = 1'b0;
        ch       = CH_SYNC;
        if (state_q != ST_IDLE && !i_wb_cyc) drop_d = 1'b1;
        unique case (state_q)
            ST_IDLE: begin
                if (i_wb_cyc && i_wb_stb) begin
                    addr_d = i_wb_addr;
                    we_d   = i_wb_we;
                    wdat_d = i_wb_dat;
                    drop_d = 1'b0;
                    fail_d = 1'b0;
                    if (resync_q)
                        state_d = ST_SYNC;
                    else if (avld_q && i_wb_addr == cache_q)
                        state_d = ST_OP_CMD;
                    else
                        state_d = ST_ADDR_CMD;
                end
            end
            ST_SYNC: begin
                req = 1'b1;
                ch  = CH_SYNC;
                if (done) begin
                    resync_d = 1'b0;
                    state_d  = addr_hit ? ST_OP_CMD : ST_ADDR_CMD;
                end
            end
            ST_ADDR_CMD: begin
                req = 1'b1;
                ch  = CH_ADDR;
                if (done) begin
                    nib_d   = 3'd0;
                    state_d = ST_ADDR_NIB;
                end
            end
            ST_ADDR_NIB: begin
                req = 1'b1;
                ch  = nib_to_hex(addr_nib);
                if (done) begin
                    if (nib_q == 3'd5) begin
                        avld_d  = 1'b1;
                        cache_d = addr_q;
                        state_d = ST_OP_CMD;
                    end else begin
                        nib_d = nib_q + 3'd1;
                    end
                end
            end
            ST_OP_CMD: begin
                req = 1'b1;
                ch  = we_q ? CH_WR : CH_RD;
                if (done) begin
                    nib_d   = 3'd0;
                    cnt_d   = '0;
                    state_d = we_q ? ST_DATA_NIB : ST_RX_HI;
                end
            end
            ST_DATA_NIB: begin
                req = 1'b1;
                ch  = nib_q[0] ? nib_to_hex(wdat_q[3:0])
                               : nib_to_hex(wdat_q[7:4]);
                if (done) begin
                    if (nib_q[0]) state_d = ST_DONE;
                    else          nib_d   = 3'd1;
                end
            end
            ST_RX_HI: begin
                if (received) begin
                    cnt_d = '0;
                    if (rx_dec.valid) begin
                        rhi_d   = rx_dec.nib;
                        state_d = ST_RX_LO;
                    end else begin
                        state_d = ST_ABORT;
                    end
                end else if (cnt_q == CNT_MAX) begin
                    state_d = ST_ABORT;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_RX_LO: begin
                if (received) begin
                    cnt_d = '0;
                    if (rx_dec.valid) begin
                        rdat_d  = {rhi_q, rx_dec.nib};
                        ack_d   = live;
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_ABORT;
                    end
                end else if (cnt_q == CNT_MAX) begin
                    state_d = ST_ABORT;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_DONE: begin
                ack_d   = live && !fail_q;
                err_d   = live && fail_q;
                state_d = ST_IDLE;
            end
            ST_ABORT: begin
                req = 1'b1;
                ch  = CH_SYNC;
                if (done) begin
                    resync_d = 1'b0;
                    fail_d   = 1'b1;
                    state_d  = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // Any error makes the remote address unknown.
        if (state_d == ST_ABORT && state_q != ST_ABORT) avld_d = 1'b0;
    end

    // State and registered bus outputs.
    always_ff @(posedge i_wb_clk or negedge i_wb_rst_n) begin
        if (!i_wb_rst_n) begin
            state_q  <= ST_IDLE;
            addr_q   <= 24'h0;
            we_q     <= 1'b0;
            wdat_q   <= 8'h00;
            cache_q  <= 24'h0;
            avld_q   <= 1'b0;
            resync_q <= 1'b1;
            nib_q    <= 3'd0;
            rhi_q    <= 4'h0;
            cnt_q    <= '0;
            drop_q   <= 1'b0;
            fail_q   <= 1'b0;
            rdat_q   <= 8'h00;
            ack_q    <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            we_q     <= we_d;
            wdat_q   <= wdat_d;
            cache_q  <= cache_d;
            avld_q   <= avld_d;
            resync_q <= resync_d;
            nib_q    <= nib_d;
            rhi_q    <= rhi_d;
            cnt_q    <= cnt_d;
            drop_q   <= drop_d;
            fail_q   <= fail_d;
            rdat_q   <= rdat_d;
            ack_q    <= ack_d;
            err_q    <= err_d;
        end
    end

    uart_char_sender u_sender (
        .clk     (i_wb_clk),
        .rst_n   (i_wb_rst_n),
        .req     (req),
        .ch      (ch),
        .tx_busy (tx_busy),
        .send    (send),
        .tx_dat  (tx_dat),
        .done    (done)
    );

    assign o_wb_dat = rdat_q;
    assign o_wb_ack = ack_q;
    assign o_wb_err = err_q;

endmodule

// File: tb/tb_wb2uart.sv
// tb_wb2uart: directed and randomized transfers through wb2uart, checked
// against a protocol-level model of the character stream and responses.
`timescale 1ns/1ps
module tb_wb2uart;

    localparam int TO = 100;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cyc = 1'b0;
    logic        stb = 1'b0;
    logic        we = 1'b0;
    logic [23:0] addr = 24'h0;
    logic [7:0]  wdat = 8'h00;
    logic [7:0]  rdat;
    logic        ack;
    logic        err;
    logic [7:0]  tx_dat;
    logic        send;
    logic        busy_q = 1'b0;
    logic        hold = 1'b0;
    logic        tx_busy;
    logic [7:0]  rx_dat = 8'h00;
    logic        received = 1'b0;

    assign tx_busy = busy_q | hold;

    always #5 clk = ~clk;

    wb2uart #(.TIMEOUT_CYCLES(TO)) dut (
        .i_wb_clk   (clk),
        .i_wb_rst_n (rst_n),
        .i_wb_cyc   (cyc),
        .i_wb_stb   (stb),
        .i_wb_we    (we),
        .i_wb_addr  (addr),
        .i_wb_dat   (wdat),
        .o_wb_dat   (rdat),
        .o_wb_ack   (ack),
        .o_wb_err   (err),
        .tx_dat     (tx_dat),
        .send       (send),
        .tx_busy    (tx_busy),
        .rx_dat     (rx_dat),
        .received   (received)
    );

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0] txq [$];
    int   busy_left = 0;
    int   ack_n = 0;
    int   err_n = 0;
    int   send_n = 0;
    int   both_n = 0;
    int   close_n = 0;
    int   cyc_cnt = 0;
    int   last_send_t = 0;
    logic prev_send = 1'b0;
    logic ack_after_send = 1'b0;

    string hexs = "0123456789ABCDEF";
    logic [7:0] bad_tab [7] = '{8'h67, 8'h61, 8'h2F, 8'h3A,
                               8'h40, 8'h47, 8'h2E};

    logic        m_resync = 1'b1;
    logic        m_vld = 1'b0;
    logic [23:0] m_cache = 24'h0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // UART side: log characters, model a transmitter busy window.
    always @(negedge clk) begin
        cyc_cnt   <= cyc_cnt + 1;
        prev_send <= send;
        if (send) begin
            txq.push_back(tx_dat);
            send_n      <= send_n + 1;
            last_send_t <= cyc_cnt;
            busy_q      <= 1'b1;
            busy_left   <= $urandom_range(1, 6);
        end else if (busy_left > 1) begin
            busy_left <= busy_left - 1;
        end else begin
            busy_left <= 0;
            busy_q    <= 1'b0;
        end
        if (send && prev_send) close_n <= close_n + 1;
        if (ack) begin
            ack_n          <= ack_n + 1;
            ack_after_send <= prev_send;
        end
        if (err) err_n <= err_n + 1;
        if (ack && err) both_n <= both_n + 1;
    end

    function automatic logic [3:0] hexval(input logic [7:0] c);
        if (c >= 8'h41) return 4'(c - 8'h37);
        return 4'(c - 8'h30);
    endfunction

    // Master releases the bus as soon as it sees a completion.
    task automatic tk();
        @(negedge clk);
        #1;
        if (cyc && (ack || err)) begin
            cyc = 1'b0;
            stb = 1'b0;
        end
    endtask

    task automatic wait_tx(input int base, input int n);
        int i;
        for (i = 0; i < 3000; i++) begin
            if (txq.size() - base >= n) break;
            tk();
        end
        if (i == 3000) chk("tx_wait_expired", 0, 1);
    endtask

    task automatic wait_done();
        int i;
        for (i = 0; i < 3000; i++) begin
            if (!cyc) break;
            tk();
        end
        if (i == 3000) begin
            chk("done_wait_expired", 0, 1);
            cyc = 1'b0;
            stb = 1'b0;
        end
    endtask

    // mode (reads): 0 no reply, 1 reply hc/lc, 2 bad hc, 3 bad lc
    // evt: 0 none, 1 tx hold, 2 reset, 3 drop cyc, 4 first-send latency
    task automatic xfer(input logic w, input logic [23:0] a,
                        input logic [7:0] d, input int mode,
                        input logic [7:0] hc, input logic [7:0] lc,
                        input int evt, input int at);
        logic [7:0] ex [$];
        logic [7:0] b;
        int   base, n_cmd, a0, e0, s0, r_t, dly;
        logic bad;
        int   exp_ack;
        bad = !w && mode != 1;
        if (m_resync) ex.push_back(8'h2E);
        if (!(m_vld && m_cache == a)) begin
            ex.push_back(8'h70);
            for (int k = 0; k < 3; k++) begin
                b = 8'(a >> (8 * k));
                ex.push_back(hexs[b[7:4]]);
                ex.push_back(hexs[b[3:0]]);
            end
        end
        ex.push_back(w ? 8'h77 : 8'h72);
        if (w) begin
            ex.push_back(hexs[d[7:4]]);
            ex.push_back(hexs[d[3:0]]);
        end
        n_cmd = ex.size();
        if (bad) ex.push_back(8'h2E);
        exp_ack = (evt == 3 || bad) ? 0 : 1;

        base = txq.size();
        a0 = ack_n;
        e0 = err_n;
        cyc = 1'b1; stb = 1'b1; we = w; addr = a; wdat = d;

        if (evt == 4) begin
            tk();
            chk("first_send_early", 32'(send), 0);
            tk();
            chk("first_send", 32'(send), 1);
        end
        if (evt == 1) begin
            wait_tx(base, at);
            hold = 1'b1;
            s0 = send_n;
            repeat (50) tk();
            chk("hold_quiet", send_n - s0, 0);
            hold = 1'b0;
        end
        if (evt == 2) begin
            wait_tx(base, at);
            rst_n = 1'b0;
            #1;
            chk("rst_outputs", {rdat, ack, err, tx_dat, send}, 0);
            cyc = 1'b0; stb = 1'b0;
            tk();
            rst_n = 1'b1;
            m_resync = 1'b1;
            m_vld = 1'b0;
            repeat (8) tk();
            return;
        end
        if (evt == 3) begin
            wait_tx(base, at);
            cyc = 1'b0; stb = 1'b0;
            wait_tx(base, n_cmd);
            repeat (8) tk();
        end else if (w) begin
            if (evt == 0) begin
                wait_tx(base, 2);
                rx_dat = 8'h35; received = 1'b1;
                tk();
                received = 1'b0;
            end
            wait_done();
        end else begin
            wait_tx(base, n_cmd);
            r_t = last_send_t;
            if (mode != 0) begin
                repeat ($urandom_range(1, 8)) tk();
                rx_dat = hc; received = 1'b1;
                tk();
                received = 1'b0;
                if (mode != 2) begin
                    repeat ($urandom_range(1, 8)) tk();
                    rx_dat = lc; received = 1'b1;
                    tk();
                    received = 1'b0;
                    if (mode == 1) begin
                        chk("rd_ack_latency", 32'(ack), 1);
                        chk("rd_data", rdat, {hexval(hc), hexval(lc)});
                    end
                end
            end
            wait_done();
            if (mode == 0) begin
                dly = cyc_cnt - r_t;
                chk("timeout_window", 32'(dly >= TO && dly <= TO + 15), 1);
            end
        end
        repeat (4) tk();

        chk("n_chars", txq.size() - base, ex.size());
        for (int i = 0; i < ex.size(); i++)
            if (base + i < txq.size())
                chk($sformatf("char%0d", i), txq[base + i], ex[i]);
        chk("acks", ack_n - a0, exp_ack);
        chk("errs", err_n - e0, 32'(bad));
        if (w && evt != 3) chk("wr_ack_after_send", 32'(ack_after_send), 1);

        m_resync = 1'b0;
        if (bad) begin
            m_vld = 1'b0;
        end else begin
            m_vld = 1'b1;
            m_cache = a;
        end
    endtask

    initial begin
        logic [23:0] pool [3];
        logic [23:0] a;
        logic [7:0]  hc, lc;
        int          r;
        pool[0] = 24'h000010;
        pool[1] = 24'h123456;
        pool[2] = 24'hFFFFFF;

        repeat (3) tk();
        chk("reset_outputs", {rdat, ack, err, tx_dat, send}, 0);
        rst_n = 1'b1;
        repeat (3) tk();

        xfer(1'b1, 24'h123456, 8'hA5, 0, 8'h0, 8'h0, 4, 0);
        xfer(1'b1, 24'h123456, 8'h0F, 0, 8'h0, 8'h0, 0, 0);
        xfer(1'b0, 24'h000010, 8'h00, 1, 8'h43, 8'h39, 0, 0);
        xfer(1'b0, 24'h000010, 8'h00, 0, 8'h0, 8'h0, 0, 0);
        xfer(1'b0, 24'h000010, 8'h00, 1, 8'h46, 8'h30, 0, 0);
        xfer(1'b0, 24'h000010, 8'h00, 2, 8'h67, 8'h0, 0, 0);
        xfer(1'b1, 24'hABCDEF, 8'h5A, 0, 8'h0, 8'h0, 1, 4);
        xfer(1'b1, 24'h555555, 8'h11, 0, 8'h0, 8'h0, 2, 3);
        xfer(1'b1, 24'h555555, 8'h22, 0, 8'h0, 8'h0, 0, 0);
        xfer(1'b1, 24'h010203, 8'h33, 0, 8'h0, 8'h0, 3, 2);
        xfer(1'b0, 24'h010203, 8'h00, 1, 8'h37, 8'h45, 0, 0);

        for (int t = 0; t < 40; t++) begin
            a = ($urandom_range(0, 3) == 3) ? 24'($urandom)
                                            : pool[$urandom_range(0, 2)];
            hc = hexs[$urandom_range(0, 15)];
            lc = hexs[$urandom_range(0, 15)];
            r = $urandom_range(0, 9);
            if ($urandom_range(0, 1) == 1) begin
                xfer(1'b1, a, 8'($urandom), 0, hc, lc, 0, 0);
            end else if (r == 0) begin
                xfer(1'b0, a, 8'h00, 0, hc, lc, 0, 0);
            end else if (r == 1) begin
                xfer(1'b0, a, 8'h00, 2, bad_tab[$urandom_range(0, 6)],
                     lc, 0, 0);
            end else if (r == 2) begin
                xfer(1'b0, a, 8'h00, 3, hc,
                     bad_tab[$urandom_range(0, 6)], 0, 0);
            end else begin
                xfer(1'b0, a, 8'h00, 1, hc, lc, 0, 0);
            end
        end

        chk("send_spacing", close_n, 0);
        chk("ack_err_exclusive", both_n, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/wb2uart.md
# wb2uart

Wishbone slave that tunnels 8-bit bus cycles over a UART link to a remote `uart2wb` bridge, using the same ASCII command protocol. It sits between a local Wishbone master and a UART transmitter/receiver pair:
- It encodes each write or read as a command character stream.
- For reads, it decodes the two-character hex reply into read data.

It caches the remote address to skip redundant `p` sequences and recovers from lost or garbled replies by timeout and resync.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 1000000: clock cycles allowed between read-reply characters before the read is aborted.

Ports:
- `i_wb_clk`  in  1  clock.
- `i_wb_rst_n`  in  1  reset; one clock, reset is asynchronous and active-low.
- `i_wb_cyc`  in  1  bus cycle.
- `i_wb_stb`  in  1  strobe.
- `i_wb_we`  in  1  1 = write.
- `i_wb_addr`  in  24  remote byte address.
- `i_wb_dat`  in  8  write data.
- `o_wb_dat`  out  8  read data, valid with `o_wb_ack`.
- `o_wb_ack`  out  1  one-cycle completion pulse.
- `o_wb_err`  out  1  one-cycle error pulse (timeout or bad reply).
- `tx_dat`  out  8  character to transmit.
- `send`  out  1  one-cycle transmit strobe.
- `tx_busy`  in  1  UART transmitter busy; it rises the cycle after `send`.
- `rx_dat`  in  8  received character.
- `received`  in  1  one-cycle receive strobe.

## Operation
Protocol characters:
- `.` 0x2E: resync.
- `p` 0x70: set address.
- `w` 0x77: write.
- `r` 0x72: read.
- Hex digits: 0–9 = 0x30–0x39, A–F = 0x41–0x46. Uppercase only, both directions.

Sequences:
- Address sequence: `p` followed by 6 nibbles in order addr[7:4], [3:0], [15:12], [11:8], [23:20], [19:16].
- Write: [`.`] [address sequence] `w` hi-nibble lo-nibble. Completes with `o_wb_ack` after the last character is sent; the remote sends no reply.
- Read: [`.`] [address sequence] `r`. The block then expects two hex characters, high nibble first, and returns `o_wb_dat` = {hi,lo} with `o_wb_ack`.

Prefix rules:
- `.` is sent only when the resync flag is set. The flag is set by reset and by any error, and cleared when `.` is sent.
- The address sequence is skipped when the address-valid flag is set and `i_wb_addr` equals the cached address.
- The address-valid flag is cleared by reset and by any error, and set after an address sequence is sent.

State machine:
- States: IDLE, SYNC, ADDR_CMD, ADDR_NIB(0..5), OP_CMD, DATA_NIB(0..1), RX_HI, RX_LO, DONE, ABORT.
- IDLE: latches addr, we and dat when `i_wb_cyc & i_wb_stb` are high. Requests are sampled only in IDLE.
- Character emit: `send` pulses when the character is ready, `tx_busy`=0, and no `send` occurred in the previous cycle. `tx_dat` is held until the next character.
- RX_HI/RX_LO: a non-hex character → ABORT.
- ABORT: sends `.`, then pulses `o_wb_err`.
- `received` outside RX_HI/RX_LO is ignored.
- Timeout: the counter clears on entry to RX_HI and on each `received`. Reaching TIMEOUT_CYCLES → ABORT. Counter width is $clog2(TIMEOUT_CYCLES+1).
- Master drops `i_wb_cyc` mid-transfer: the serial sequence runs to completion (including the reply), `o_wb_ack`/`o_wb_err` are suppressed, and the block returns to IDLE.

## Timing
- Reset values: `o_wb_dat`=0, `o_wb_ack`=0, `o_wb_err`=0, `tx_dat`=0, `send`=0. State=IDLE, resync flag=1, address-valid flag=0.
- Reset mid-sequence aborts immediately; the partial stream is abandoned and recovered by the `.` prefix.
- First `send` occurs 1 cycle after the strobe is sampled in IDLE, if `tx_busy`=0.
- Minimum spacing between `send` pulses: 2 cycles.
- Write: `o_wb_ack` is asserted the cycle after the last `send`.
- Read: `o_wb_ack` and `o_wb_dat` are asserted the cycle after the second `received`.
- `o_wb_ack` and `o_wb_err` are mutually exclusive and each lasts exactly 1 cycle. The block returns to IDLE the same cycle.

## Structure
- Package `uart_proto_pkg` holds:
  - character constants (`.`, `p`, `w`, `r`);
  - the nibble→ASCII function;
  - the ASCII→nibble/valid function.
  `uart2wb` also uses this package.
- Sub-module `uart_char_sender`: takes a character plus a request, handles `tx_busy`, the 1-cycle holdoff and the `send` pulse, and returns `done`.

## Test plan
- After reset, write addr 0x123456, data 0xA5 → `tx_dat` sequence 2E 70 35 36 33 34 31 32 77 41 35; `o_wb_ack` the cycle after the last `send`.
- Next write to the same address, data 0x0F → only 77 30 46; ack.
- Read addr 0x000010, reply 0x43 then 0x39 → sent 70 31 30 30 30 30 30 72; `o_wb_dat`=0xC9 with ack.
- Read with no reply, TIMEOUT_CYCLES=100 → after 100 cycles sends 2E, `o_wb_err` pulse. Next read of the same address resends 70 plus 6 nibbles.
- Read reply 0x67 (`g`) → sends 2E, `o_wb_err`; `o_wb_ack` never asserted.
- `tx_busy` held high for 50 cycles mid-address → no `send` pulses during the hold, and the sequence resumes intact. Asserting `i_wb_rst_n`=0 mid-address → all outputs 0 immediately, and the next transfer begins with 2E.
